// File: rtl/param_counter_datapath_if.sv
// Control and status bundle for the parameterised tick counter.
// The master side drives run/mode/clear/load/load_val; the counter
// (slave side) returns count and the tick/wrap/done flags.
interface param_counter_datapath_if #(
    parameter int unsigned WIDTH = 14
);
    logic             run;
    logic             mode;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             wrap;
    logic             done;

    modport master (
        output run, mode, clear, load, load_val,
        input  count, tick, wrap, done
    );

    modport slave (
        input  run, mode, clear, load, load_val,
        output count, tick, wrap, done
    );
endinterface

// File: rtl/param_counter_datapath.sv
// Divided-clock up/down counter.
// A DIV-cycle divider produces a tick.
// Each tick steps a modulo-MAX count up or down.
// In one-shot mode the count parks at its terminal value until clear or load.
module param_counter_datapath #(
    parameter int unsigned DIV      = 10_000_000,
    parameter int unsigned MAX      = 10_000,
    parameter int unsigned WIDTH    = 14,
    parameter int unsigned ONE_SHOT = 0
) (
    input logic                     clk,
    input logic                     rst,
    param_counter_datapath_if.slave bus
);
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]    DIV_M1 = DW'(DIV - 1);
    localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(MAX - 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    // Next state: clear beats load beats the divider tick; DONE freezes everything.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        done_d  = done_q;

        if (bus.clear) begin
            state_d = ST_RUN;
            div_d   = '0;
            count_d = '0;
            done_d  = 1'b0;
        end else if (bus.load) begin
            // Divider is left alone; any tick due this cycle is dropped.
            state_d = ST_RUN;
            done_d  = 1'b0;
            count_d = (32'(bus.load_val) >= MAX) ? MAX_M1 : bus.load_val;
        end else if (state_q == ST_RUN && bus.run) begin
            if (div_q == DIV_M1) begin
                div_d  = '0;
                tick_d = 1'b1;
                if (!bus.mode) begin
                    if (count_q == MAX_M1) begin
                        wrap_d = 1'b1;
                        if (ONE_SHOT != 0) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            count_d = '0;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    if (count_q == '0) begin
                        wrap_d = 1'b1;
                        if (ONE_SHOT != 0) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            count_d = MAX_M1;
                        end
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            div_q   <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick_q;
    assign bus.wrap  = wrap_q;
    assign bus.done  = (ONE_SHOT != 0) ? done_q : 1'b0;
endmodule

// File: tb/tb_param_counter_datapath.sv
// Bench for param_counter_datapath.
// Two instances run side by side with DIV=4, MAX=10, WIDTH=4:
// one free-running and one one-shot.
// Both are compared every cycle against a behavioural model.
module tb_param_counter_datapath;
    localparam int DIV = 4;
    localparam int MAX = 10;
    localparam int W   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_counter_datapath_if #(.WIDTH(W)) if_free ();
    param_counter_datapath_if #(.WIDTH(W)) if_shot ();

    param_counter_datapath #(.DIV(DIV), .MAX(MAX), .WIDTH(W), .ONE_SHOT(0)) dut_free (
        .clk(clk), .rst(rst), .bus(if_free.slave)
    );
    param_counter_datapath #(.DIV(DIV), .MAX(MAX), .WIDTH(W), .ONE_SHOT(1)) dut_shot (
        .clk(clk), .rst(rst), .bus(if_shot.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = free-running, 1 = one-shot
    int phase [2];   // cycles elapsed in the current divider interval
    int cnt   [2];
    int m_tick[2];
    int m_wrap[2];
    int m_done[2];
    int oneshot[2] = '{0, 1};

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit rn, input bit md,
                              input bit cl, input bit ld, input int lv);
        int nxt;
        bit wrapped;
        for (int k = 0; k < 2; k++) begin
            if (r || cl) begin
                phase[k] = 0; cnt[k] = 0;
                m_tick[k] = 0; m_wrap[k] = 0; m_done[k] = 0;
            end else if (ld) begin
                cnt[k] = (lv >= MAX) ? MAX - 1 : lv;
                m_done[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
            end else begin
                m_tick[k] = 0; m_wrap[k] = 0;
                if (!m_done[k] && rn) begin
                    phase[k]++;
                    if (phase[k] == DIV) begin
                        phase[k] = 0;
                        m_tick[k] = 1;
                        nxt = md ? (cnt[k] + MAX - 1) % MAX : (cnt[k] + 1) % MAX;
                        wrapped = md ? (nxt > cnt[k]) : (nxt < cnt[k]);
                        if (wrapped) begin
                            m_wrap[k] = 1;
                            if (oneshot[k] != 0) m_done[k] = 1;
                            else cnt[k] = nxt;
                        end else begin
                            cnt[k] = nxt;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit rn, input bit md,
                        input bit cl, input bit ld, input int lv);
        rst = r;
        if_free.run = rn; if_free.mode = md; if_free.clear = cl;
        if_free.load = ld; if_free.load_val = W'(lv);
        if_shot.run = rn; if_shot.mode = md; if_shot.clear = cl;
        if_shot.load = ld; if_shot.load_val = W'(lv);
        @(posedge clk);
        model_edge(r, rn, md, cl, ld, lv);
        #1;
        chk("free.count", int'(if_free.count), cnt[0]);
        chk("free.tick",  int'(if_free.tick),  m_tick[0]);
        chk("free.wrap",  int'(if_free.wrap),  m_wrap[0]);
        chk("free.done",  int'(if_free.done),  m_done[0]);
        chk("shot.count", int'(if_shot.count), cnt[1]);
        chk("shot.tick",  int'(if_shot.tick),  m_tick[1]);
        chk("shot.wrap",  int'(if_shot.wrap),  m_wrap[1]);
        chk("shot.done",  int'(if_shot.done),  m_done[1]);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            phase[k] = 0; cnt[k] = 0; m_tick[k] = 0; m_wrap[k] = 0; m_done[k] = 0;
        end

        // Reset
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1, 5);

        // Up count: 44 cycles, wrap at 9->0 (one-shot parks at 9)
        for (int i = 0; i < 44; i++) step(0, 1, 0, 0, 0, 0);
        // One-shot stays parked while run continues
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0);

        // Down count from 0 with a 7-cycle pause mid-interval
        step(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 0);

        // Load coinciding with a due tick, then an out-of-range load
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 7);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 12);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);

        // Mode change mid-interval
        for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0);

        // clear and load together: clear wins
        step(0, 1, 0, 1, 1, 6);
        for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 0);
        // Reset against clear, load and run mid-interval
        step(1, 1, 0, 1, 1, 6);
        step(0, 1, 0, 0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < 75),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 24) == 0),
                 int'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
